ddr3_dfi_seq_param: RTL
=======================

DDR3_DFI_SEQ_PARAM -- requirements
Module: ddr3_dfi_seq_param

Interface
REQ-001 SHALL have parameter DDR_MHZ, default 100: DFI clock frequency in MHz; CYCLE_NS = 1000/DDR_MHZ.
REQ-002 SHALL have parameter DDR_WRITE_LATENCY, default 6: cycles from WRITE on DFI to first dfi_wrdata_en_o.
REQ-003 SHALL have parameter DDR_READ_LATENCY, default 5: cycles from READ on DFI to first dfi_rddata_en_o.
REQ-004 SHALL have parameter DDR_BURST_LEN, default 4: DFI beats per burst; legal values 2, 4, 8.
REQ-005 SHALL have parameter DFI_DATA_W, default 32: DFI data width; mask width is DFI_DATA_W/8.
REQ-006 SHALL have parameter WR_FIFO_DEPTH, default 4: write-data FIFO entries; power of 2, at least 2.
REQ-007 SHALL have parameters DDR_ROW_W, default 15, and DDR_BANK_W, default 3.
REQ-008 SHALL define HOST_W = DFI_DATA_W*DDR_BURST_LEN.
REQ-009 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-010 rst_i  in  1  reset; asynchronous assert, active-low.
REQ-011 address_i  in  DDR_ROW_W  and  bank_i  in  DDR_BANK_W: address and bank for command_i.
REQ-012 command_i  in  4  {cs_n,ras_n,cas_n,we_n}: NOP=0111, ACT=0011, RD=0101, WR=0100, ZQCL=0110, PRE=0010, REF=0001, MRS=0000.
REQ-013 cke_i  in  1  clock enable, registered to dfi_cke_o.
REQ-014 accept_o  out  1  command_i is taken this cycle.
REQ-015 wrdata_i  in  HOST_W  and  wrdata_mask_i  in  HOST_W/8: burst data, pushed with an accepted WR.
REQ-016 rddata_valid_o  out  1  and  rddata_o  out  HOST_W: completed read burst.
REQ-017 busy_o  out  1  timing counter non-zero.
REQ-018 dfi_address_o, dfi_bank_o, dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o, dfi_cke_o, dfi_odt_o, dfi_reset_n_o  out  DFI command/control signals.
REQ-019 dfi_wrdata_o  out  DFI_DATA_W;  dfi_wrdata_mask_o  out  DFI_DATA_W/8;  dfi_wrdata_en_o  out  1;  dfi_rddata_en_o  out  1.
REQ-020 dfi_rddata_i  in  DFI_DATA_W;  dfi_rddata_valid_i  in  1;  dfi_rddata_dnv_i  in  2, ignored.

Function
REQ-021 Timing: tRCD = tRP = ceil(15/CYCLE_NS); tRFC = ceil(260/CYCLE_NS); TURN = DDR_WRITE_LATENCY + DDR_BURST_LEN + 6; the counter is 8 bits wide.
REQ-022 NOP is always accepted and does not load the counter.
REQ-023 With counter 0: ACT loads tRCD, PRE loads tRP, REF loads tRFC, RD/WR load TURN, and MRS/ZQCL load 0.
REQ-024 With counter non-zero and no early accept, the counter decrements by 1 per cycle.
REQ-025 Early accept: RD after RD, or WR after WR, is accepted when counter == TURN - DDR_BURST_LEN, and reloads the counter to TURN.
REQ-026 A WR is accepted only while the write FIFO is not full; a full FIFO holds accept_o low for that WR.
REQ-027 An accepted command appears on dfi_* exactly 1 cycle later, with its address and bank.
REQ-028 A non-accepted cycle drives NOP with address and bank 0.
REQ-029 dfi_odt_o SHALL be 0 and dfi_reset_n_o SHALL be 1.
REQ-030 For a WR on DFI in cycle C, dfi_wrdata_en_o is high in cycles C+DDR_WRITE_LATENCY .. C+DDR_WRITE_LATENCY+DDR_BURST_LEN-1.
REQ-031 Beat k carries wrdata[k*DFI_DATA_W +: DFI_DATA_W] and the matching mask slice; data and mask are 0 when dfi_wrdata_en_o is low.
REQ-032 The FIFO entry is popped on the last beat, and the beat index wraps modulo DDR_BURST_LEN.
REQ-033 Read timing mirrors write timing using DDR_READ_LATENCY and dfi_rddata_en_o.
REQ-034 Each dfi_rddata_valid_i beat is written into slice k of the read buffer, and k wraps modulo DDR_BURST_LEN.
REQ-035 rddata_valid_o pulses for 1 cycle, the cycle after the last beat, with the full burst on rddata_o.
REQ-036 Back-to-back same-type bursts at the early-accept spacing produce a gapless enable stream.

Reset
REQ-037 While rst_i is low, all state clears immediately, regardless of any operation in flight.
REQ-038 During reset: dfi command = NOP, address/bank/data/mask = 0, enables = 0, dfi_cke_o = 0, rddata_valid_o = 0, rddata_o = 0, counter = 0, FIFO empty, beat indices 0.
REQ-039 The first cycle after reset release accepts any command.

Verification (defaults: tRCD=2, tRP=2, tRFC=26, TURN=16)
REQ-040 ACT at cycle 0, then RD held -> ACT on DFI at cycle 1; RD accepted at cycle 2; dfi_rddata_en_o high at cycles 8-11.
REQ-041 WR (data 0x4..0x1 beats, mask 0) at cycle 0 -> dfi_wrdata_en_o high at cycles 7-10; dfi_wrdata_o = 0x1, 0x2, 0x3, 0x4.
REQ-042 Two WRs presented back-to-back -> second accepted at cycle 4; dfi_wrdata_en_o continuous for 8 cycles; FIFO empty afterwards.
REQ-043 WR then RD -> RD accepted only when counter reaches 0, at cycle 16.
REQ-044 4 read beats 0xA, 0xB, 0xC, 0xD -> rddata_valid_o pulses once with rddata_o = 0x0000000D_0000000C_0000000B_0000000A.
REQ-045 rst_i low mid-burst -> dfi_wrdata_en_o = 0 and FIFO empty immediately; REF accepted in the first cycle after release; busy_o high for 26 cycles.

Source files
------------

// File: rtl/ddr3_dfi_seq_param_if.sv
// Host-command and DFI bundle for the DDR3 DFI sequencer. The sequencer takes
// the slave view; the host/PHY side takes the master view.
interface ddr3_dfi_seq_param_if #(
    parameter int DDR_ROW_W     = 15,
    parameter int DDR_BANK_W    = 3,
    parameter int DFI_DATA_W    = 32,
    parameter int DDR_BURST_LEN = 4
);
    localparam int HOST_W = DFI_DATA_W * DDR_BURST_LEN;

    // Host side
    logic [DDR_ROW_W-1:0]    address_i;
    logic [DDR_BANK_W-1:0]   bank_i;
    logic [3:0]              command_i;
    logic                    cke_i;
    logic                    accept_o;
    logic [HOST_W-1:0]       wrdata_i;
    logic [HOST_W/8-1:0]     wrdata_mask_i;
    logic                    rddata_valid_o;
    logic [HOST_W-1:0]       rddata_o;
    logic                    busy_o;

    // DFI side
    logic [DDR_ROW_W-1:0]    dfi_address_o;
    logic [DDR_BANK_W-1:0]   dfi_bank_o;
    logic                    dfi_cs_n_o;
    logic                    dfi_ras_n_o;
    logic                    dfi_cas_n_o;
    logic                    dfi_we_n_o;
    logic                    dfi_cke_o;
    logic                    dfi_odt_o;
    logic                    dfi_reset_n_o;
    logic [DFI_DATA_W-1:0]   dfi_wrdata_o;
    logic [DFI_DATA_W/8-1:0] dfi_wrdata_mask_o;
    logic                    dfi_wrdata_en_o;
    logic                    dfi_rddata_en_o;
    logic [DFI_DATA_W-1:0]   dfi_rddata_i;
    logic                    dfi_rddata_valid_i;
    logic [1:0]              dfi_rddata_dnv_i;

    modport slave (
        input  address_i, bank_i, command_i, cke_i, wrdata_i, wrdata_mask_i,
               dfi_rddata_i, dfi_rddata_valid_i, dfi_rddata_dnv_i,
        output accept_o, rddata_valid_o, rddata_o, busy_o,
               dfi_address_o, dfi_bank_o, dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o,
               dfi_we_n_o, dfi_cke_o, dfi_odt_o, dfi_reset_n_o, dfi_wrdata_o,
               dfi_wrdata_mask_o, dfi_wrdata_en_o, dfi_rddata_en_o
    );

    modport master (
        output address_i, bank_i, command_i, cke_i, wrdata_i, wrdata_mask_i,
               dfi_rddata_i, dfi_rddata_valid_i, dfi_rddata_dnv_i,
        input  accept_o, rddata_valid_o, rddata_o, busy_o,
               dfi_address_o, dfi_bank_o, dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o,
               dfi_we_n_o, dfi_cke_o, dfi_odt_o, dfi_reset_n_o, dfi_wrdata_o,
               dfi_wrdata_mask_o, dfi_wrdata_en_o, dfi_rddata_en_o
    );
endinterface

// File: rtl/ddr3_dfi_seq_param.sv
// DDR3 DFI command sequencer: one shared timing counter gates host commands,
// a write-data FIFO and latency shift registers generate the DFI data phases.
module ddr3_dfi_seq_param #(
    parameter int DDR_MHZ           = 100,
    parameter int DDR_WRITE_LATENCY = 6,
    parameter int DDR_READ_LATENCY  = 5,
    parameter int DDR_BURST_LEN     = 4,
    parameter int DFI_DATA_W        = 32,
    parameter int WR_FIFO_DEPTH     = 4,
    parameter int DDR_ROW_W         = 15,
    parameter int DDR_BANK_W        = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ddr3_dfi_seq_param_if.slave bus
);
    localparam int HOST_W  = DFI_DATA_W * DDR_BURST_LEN;
    localparam int MASK_W  = DFI_DATA_W / 8;
    localparam int HMASK_W = HOST_W / 8;
    localparam int T_RCD   = (15 * DDR_MHZ + 999) / 1000;
    localparam int T_RP    = T_RCD;
    localparam int T_RFC   = (260 * DDR_MHZ + 999) / 1000;
    localparam int TURN    = DDR_WRITE_LATENCY + DDR_BURST_LEN + 6;
    localparam int BEAT_W  = $clog2(DDR_BURST_LEN);
    localparam int FA_W    = $clog2(WR_FIFO_DEPTH);
    localparam int WR_SR_W = DDR_WRITE_LATENCY + DDR_BURST_LEN - 1;
    localparam int RD_SR_W = DDR_READ_LATENCY + DDR_BURST_LEN - 1;

    localparam logic [3:0] CMD_MRS = 4'b0000, CMD_REF = 4'b0001, CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_ACT = 4'b0011, CMD_WR  = 4'b0100, CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    // Commands are gated on the post-decrement count, so a load of N lets the
    // next command in exactly N cycles after the loading one.
    localparam logic [7:0] CNT_EARLY = 8'(TURN - DDR_BURST_LEN + 1);

    typedef enum logic [1:0] {LAST_OTHER, LAST_RD, LAST_WR} last_e;

    logic [7:0]            r_cnt;
    last_e                 r_last;
    logic [3:0]            r_cmd;
    logic [DDR_ROW_W-1:0]  r_addr;
    logic [DDR_BANK_W-1:0] r_bank;
    logic                  r_cke;
    logic [WR_SR_W-1:0]    r_wr_sr;
    logic [RD_SR_W-1:0]    r_rd_sr;
    logic [HOST_W-1:0]     r_fifo_data [WR_FIFO_DEPTH];
    logic [HMASK_W-1:0]    r_fifo_mask [WR_FIFO_DEPTH];
    logic [FA_W:0]         r_wr_ptr, r_rd_ptr;
    logic [BEAT_W-1:0]     r_wr_beat, r_rd_beat;
    logic                  r_wr_en, r_rd_en, r_rvalid;
    logic [DFI_DATA_W-1:0] r_wrdata;
    logic [MASK_W-1:0]     r_wrmask;
    logic [HOST_W-1:0]     r_rdbuf, r_rddata;

    logic                  w_idle, w_is_rd, w_is_wr, w_early, w_fifo_full;
    logic                  w_accept, w_load, w_wr_beat, w_rd_beat, w_wr_last;
    logic [7:0]            w_load_val;
    logic [HOST_W-1:0]     w_head_data, w_rdbuf_next;
    logic [HMASK_W-1:0]    w_head_mask;
    logic                  w_unused_dnv;

    assign w_unused_dnv = ^bus.dfi_rddata_dnv_i;
    assign w_fifo_full  = (r_wr_ptr[FA_W] != r_rd_ptr[FA_W]) &&
                          (r_wr_ptr[FA_W-1:0] == r_rd_ptr[FA_W-1:0]);
    assign w_head_data  = r_fifo_data[r_rd_ptr[FA_W-1:0]];
    assign w_head_mask  = r_fifo_mask[r_rd_ptr[FA_W-1:0]];
    assign w_wr_beat    = |r_wr_sr[DDR_WRITE_LATENCY-1 +: DDR_BURST_LEN];
    assign w_rd_beat    = |r_rd_sr[DDR_READ_LATENCY-1 +: DDR_BURST_LEN];
    assign w_wr_last    = w_wr_beat && (r_wr_beat == BEAT_W'(DDR_BURST_LEN - 1));

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        w_idle     = bus.command_i[3] || (bus.command_i == CMD_NOP);
        w_is_rd    = (bus.command_i == CMD_RD);
        w_is_wr    = (bus.command_i == CMD_WR);
        w_early    = ((w_is_rd && r_last == LAST_RD) || (w_is_wr && r_last == LAST_WR)) &&
                     (r_cnt == CNT_EARLY);
        w_accept   = w_idle || (((r_cnt <= 8'd1) || w_early) && !(w_is_wr && w_fifo_full));
        w_load     = w_accept && !w_idle;
        w_load_val = 8'd0;
        case (bus.command_i)
            CMD_ACT:        w_load_val = 8'(T_RCD);
            CMD_PRE:        w_load_val = 8'(T_RP);
            CMD_REF:        w_load_val = 8'(T_RFC);
            CMD_RD, CMD_WR: w_load_val = 8'(TURN);
            default:        w_load_val = 8'd0;
        endcase
        w_rdbuf_next = r_rdbuf;
        w_rdbuf_next[r_rd_beat*DFI_DATA_W +: DFI_DATA_W] = bus.dfi_rddata_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt  <= 8'd0;
            r_last <= LAST_OTHER;
            r_cmd  <= CMD_NOP;
            r_addr <= '0;
            r_bank <= '0;
            r_cke  <= 1'b0;
        end else begin
            r_cke <= bus.cke_i;
            if (w_load) begin
                r_cnt  <= w_load_val;
                r_last <= w_is_rd ? LAST_RD : (w_is_wr ? LAST_WR : LAST_OTHER);
            end else if (r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
            r_cmd  <= w_accept ? bus.command_i : CMD_NOP;
            r_addr <= w_accept ? bus.address_i : '0;
            r_bank <= w_accept ? bus.bank_i    : '0;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone define its contents.
    always_ff @(posedge clk_i) begin
        if (w_load && w_is_wr) begin
            r_fifo_data[r_wr_ptr[FA_W-1:0]] <= bus.wrdata_i;
            r_fifo_mask[r_wr_ptr[FA_W-1:0]] <= bus.wrdata_mask_i;
        end
    end

    // Write phase: overlapping latency windows merge into a gapless enable.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_sr   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_wr_beat <= '0;
            r_wr_en   <= 1'b0;
            r_wrdata  <= '0;
            r_wrmask  <= '0;
        end else begin
            r_wr_sr <= {r_wr_sr[WR_SR_W-2:0], w_load && w_is_wr};
            r_wr_en <= w_wr_beat;
            if (w_load && w_is_wr) r_wr_ptr <= r_wr_ptr + (FA_W+1)'(1);
            if (w_wr_last)         r_rd_ptr <= r_rd_ptr + (FA_W+1)'(1);
            if (w_wr_beat) begin
                r_wrdata  <= w_head_data[r_wr_beat*DFI_DATA_W +: DFI_DATA_W];
                r_wrmask  <= w_head_mask[r_wr_beat*MASK_W +: MASK_W];
                r_wr_beat <= r_wr_beat + BEAT_W'(1);
            end else begin
                r_wrdata <= '0;
                r_wrmask <= '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_sr   <= '0;
            r_rd_en   <= 1'b0;
            r_rd_beat <= '0;
            r_rdbuf   <= '0;
            r_rddata  <= '0;
            r_rvalid  <= 1'b0;
        end else begin
            r_rd_sr  <= {r_rd_sr[RD_SR_W-2:0], w_load && w_is_rd};
            r_rd_en  <= w_rd_beat;
            r_rvalid <= 1'b0;
            if (bus.dfi_rddata_valid_i) begin
                r_rdbuf   <= w_rdbuf_next;
                r_rd_beat <= r_rd_beat + BEAT_W'(1);
                if (r_rd_beat == BEAT_W'(DDR_BURST_LEN - 1)) begin
                    r_rddata <= w_rdbuf_next;
                    r_rvalid <= 1'b1;
                end
            end
        end
    end

    assign bus.accept_o          = w_accept;
    assign bus.busy_o            = (r_cnt != 8'd0);
    assign bus.rddata_valid_o    = r_rvalid;
    assign bus.rddata_o          = r_rddata;
    assign bus.dfi_address_o     = r_addr;
    assign bus.dfi_bank_o        = r_bank;
    assign bus.dfi_cs_n_o        = r_cmd[3];
    assign bus.dfi_ras_n_o       = r_cmd[2];
    assign bus.dfi_cas_n_o       = r_cmd[1];
    assign bus.dfi_we_n_o        = r_cmd[0];
    assign bus.dfi_cke_o         = r_cke;
    assign bus.dfi_odt_o         = 1'b0;
    assign bus.dfi_reset_n_o     = 1'b1;
    assign bus.dfi_wrdata_o      = r_wrdata;
    assign bus.dfi_wrdata_mask_o = r_wrmask;
    assign bus.dfi_wrdata_en_o   = r_wr_en;
    assign bus.dfi_rddata_en_o   = r_rd_en;
endmodule
